// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensors and hold in, coin pulses and status out.
// The total_cents field exists only when COIN_TOTAL_EN is defined.
interface coin_acceptor_if;
  logic        coin_nickel_raw;
  logic        coin_dime_raw;
  logic        coin_quarter_raw;
  logic        hold;
  logic        nickel_pls;
  logic        dime_pls;
  logic        quarter_pls;
  logic        fifo_full;
  logic        coin_reject;
`ifdef COIN_TOTAL_EN
  logic [15:0] total_cents;

  modport slave (
    input  coin_nickel_raw, coin_dime_raw, coin_quarter_raw, hold,
    output nickel_pls, dime_pls, quarter_pls, fifo_full, coin_reject, total_cents
  );

  modport master (
    output coin_nickel_raw, coin_dime_raw, coin_quarter_raw, hold,
    input  nickel_pls, dime_pls, quarter_pls, fifo_full, coin_reject, total_cents
  );
`else
  modport slave (
    input  coin_nickel_raw, coin_dime_raw, coin_quarter_raw, hold,
    output nickel_pls, dime_pls, quarter_pls, fifo_full, coin_reject
  );

  modport master (
    output coin_nickel_raw, coin_dime_raw, coin_quarter_raw, hold,
    input  nickel_pls, dime_pls, quarter_pls, fifo_full, coin_reject
  );
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronize and debounce three coin sensors, queue coin events, and
// issue spaced one-cycle coin pulses. Optional COIN_TOTAL_EN adds a saturating cents total.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  coin_acceptor_if.slave bus
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [7:0]      DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  function automatic logic [2:0] code_to_pls(input logic [1:0] code);
    logic [2:0] pls;
    case (code)
      2'b01:   pls = 3'b001;
      2'b10:   pls = 3'b010;
      2'b11:   pls = 3'b100;
      default: pls = 3'b000;
    endcase
    return pls;
  endfunction

  logic [2:0] w_raw;
  assign w_raw = {bus.coin_quarter_raw, bus.coin_dime_raw, bus.coin_nickel_raw};

  // Stage p0/p1: two-flop synchronizer, bit 0 nickel, bit 1 dime, bit 2 quarter
  logic [2:0] r_sync_p0;
  logic [2:0] r_sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 3'b000;
      r_sync_p1 <= 3'b000;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: debounce, toggling once the mismatch has lasted DEBOUNCE_CYCLES cycles
  logic [2:0] r_db_p2;
  logic [2:0] r_db_d_p3;
  logic [7:0] r_db_cnt [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_p2   <= 3'b000;
      r_db_d_p3 <= 3'b000;
      for (int ch = 0; ch < 3; ch++) r_db_cnt[ch] <= 8'd0;
    end else begin
      r_db_d_p3 <= r_db_p2;
      for (int ch = 0; ch < 3; ch++) begin
        if (r_sync_p1[ch] != r_db_p2[ch]) begin
          if (r_db_cnt[ch] == DB_LAST) begin
            r_db_p2[ch]  <= ~r_db_p2[ch];
            r_db_cnt[ch] <= 8'd0;
          end else begin
            r_db_cnt[ch] <= r_db_cnt[ch] + 8'd1;
          end
        end else begin
          r_db_cnt[ch] <= 8'd0;
        end
      end
    end
  end

  // Stage p3: rising debounced edges become coin events, queued in priority order
  logic [2:0]    w_evt_p3;
  logic [2:0]    w_acc;
  logic          w_drop;
  logic [CW-1:0] w_nacc;
  logic [CW-1:0] w_free;
  logic [PW-1:0] w_slot [3];

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_reject;
  logic [3:0]    r_gap;
  logic [2:0]    r_pls;

  logic          w_pop;
  logic [1:0]    w_pop_code;
  logic [CW-1:0] w_count_nxt;

  assign w_evt_p3 = r_db_p2 & ~r_db_d_p3;
  // A same-cycle pop does not create room for this cycle's pushes
  assign w_free   = DEPTH_C - r_count;

  always_comb begin
    w_nacc = '0;
    w_acc  = 3'b000;
    for (int ch = 0; ch < 3; ch++) begin
      w_slot[ch] = PW'(w_nacc);
      if (w_evt_p3[ch] && (w_nacc < w_free)) begin
        w_acc[ch] = 1'b1;
        w_nacc    = w_nacc + CW'(1);
      end
    end
    w_drop = |(w_evt_p3 & ~w_acc);
  end

  assign w_pop       = (r_count != '0) && !bus.hold && (r_gap == 4'd0);
  assign w_pop_code  = r_mem[r_rd_ptr];
  assign w_count_nxt = r_count + w_nacc - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 2'b00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        if (w_acc[ch]) r_mem[r_wr_ptr + w_slot[ch]] <= 2'(ch + 1);
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_nacc);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_reject <= w_drop;
    end
  end

  // Stage p4: registered coin pulse plus inter-pulse gap timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pls <= 3'b000;
      r_gap <= 4'd0;
    end else begin
      r_pls <= w_pop ? code_to_pls(w_pop_code) : 3'b000;
      if (w_pop) begin
        r_gap <= GAP_LOAD;
      end else if (r_gap != 4'd0) begin
        r_gap <= r_gap - 4'd1;
      end
    end
  end

  assign bus.nickel_pls  = r_pls[0];
  assign bus.dime_pls    = r_pls[1];
  assign bus.quarter_pls = r_pls[2];
  assign bus.fifo_full   = r_full;
  assign bus.coin_reject = r_reject;

`ifdef COIN_TOTAL_EN
  function automatic logic [4:0] code_to_cents(input logic [1:0] code);
    logic [4:0] cents;
    case (code)
      2'b01:   cents = 5'd5;
      2'b10:   cents = 5'd10;
      2'b11:   cents = 5'd25;
      default: cents = 5'd0;
    endcase
    return cents;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [4:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {12'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [15:0] r_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= 16'd0;
    end else if (w_pop) begin
      r_total <= sat_add(r_total, code_to_cents(w_pop_code));
    end
  end

  assign bus.total_cents = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, multi-cycle corner sequences, and
// random stimulus checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_coin_acceptor;

  localparam int DB    = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coin_acceptor_if bus();

  coin_acceptor #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pls_vec();
    return {bus.quarter_pls, bus.dime_pls, bus.nickel_pls};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_raw(input logic [2:0] v);
    bus.coin_nickel_raw  = v[0];
    bus.coin_dime_raw    = v[1];
    bus.coin_quarter_raw = v[2];
  endtask

  // Reference model: coins as a queue of codes, pops spaced by edge index arithmetic
  int         m_cyc      = 0;
  int         m_last_pop = -100;
  logic [2:0] m_s1 = 3'b000, m_s2 = 3'b000, m_db = 3'b000, m_dbd = 3'b000;
  int         m_run [3]  = '{0, 0, 0};
  int         m_q [$];
  logic [2:0] m_exp_pls  = 3'b000;
  logic       m_exp_full = 1'b0;
  logic       m_exp_rej  = 1'b0;
  int         m_exp_total = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_last_pop = -100;
      m_s1 = 3'b000; m_s2 = 3'b000; m_db = 3'b000; m_dbd = 3'b000;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
      m_q.delete();
      m_exp_pls = 3'b000; m_exp_full = 1'b0; m_exp_rej = 1'b0; m_exp_total = 0;
    end else begin : step
      logic [2:0] ev;
      int free;
      int code;
      logic [2:0] raw;
      raw = {bus.coin_quarter_raw, bus.coin_dime_raw, bus.coin_nickel_raw};
      m_cyc++;
      ev   = m_db & ~m_dbd;
      free = DEPTH - m_q.size();
      m_exp_pls = 3'b000;
      if (m_q.size() > 0 && !bus.hold && (m_cyc - m_last_pop > GAP)) begin
        code = m_q.pop_front();
        m_exp_pls = 3'b001 << (code - 1);
        m_last_pop = m_cyc;
        m_exp_total += (code == 1) ? 5 : (code == 2) ? 10 : 25;
        if (m_exp_total > 65535) m_exp_total = 65535;
      end
      m_exp_rej = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (ev[c]) begin
          if (free > 0) begin
            m_q.push_back(c + 1);
            free--;
          end else begin
            m_exp_rej = 1'b1;
          end
        end
      end
      m_exp_full = (m_q.size() == DEPTH);
      m_dbd = m_db;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[c] != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_db[c]  = ~m_db[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(negedge clk) begin
    check("model_pulses", pls_vec(), m_exp_pls);
    check("model_fifo_full", bus.fifo_full, m_exp_full);
    check("model_reject", bus.coin_reject, m_exp_rej);
    check("pulse_onehot", $countones(pls_vec()) <= 1, 1);
`ifdef COIN_TOTAL_EN
    check("model_total", bus.total_cents, m_exp_total);
`endif
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] raw;
    logic [2:0] at8;
    logic [2:0] at11;
    logic [2:0] at14;
  } vec_t;

  vec_t vecs [8];
  int   g_rej;
  int   g_pls [3];

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic observe();
    g_rej += bus.coin_reject;
    g_pls[0] += bus.nickel_pls;
    g_pls[1] += bus.dime_pls;
    g_pls[2] += bus.quarter_pls;
  endtask

  task automatic quarter_coin();
    bus.coin_quarter_raw = 1'b1;
    repeat (8) begin tick(); observe(); end
    bus.coin_quarter_raw = 1'b0;
    repeat (8) begin tick(); observe(); end
  endtask

  initial begin
    vecs[0] = '{"nickel",  3'b001, 3'b001, 3'b000, 3'b000};
    vecs[1] = '{"dime",    3'b010, 3'b010, 3'b000, 3'b000};
    vecs[2] = '{"quarter", 3'b100, 3'b100, 3'b000, 3'b000};
    vecs[3] = '{"n_d",     3'b011, 3'b001, 3'b010, 3'b000};
    vecs[4] = '{"d_q",     3'b110, 3'b010, 3'b100, 3'b000};
    vecs[5] = '{"n_q",     3'b101, 3'b001, 3'b100, 3'b000};
    vecs[6] = '{"n_d_q",   3'b111, 3'b001, 3'b010, 3'b100};
    vecs[7] = '{"none",    3'b000, 3'b000, 3'b000, 3'b000};

    set_raw(3'b000);
    bus.hold = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_pulses", pls_vec(), 0);
    check("reset_fifo_full", bus.fifo_full, 0);
    check("reset_reject", bus.coin_reject, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed table: rise held 10 cycles, pulses expected at cycles 8/11/14
    for (int v = 0; v < 8; v++) begin
      set_raw(vecs[v].raw);
      for (int k = 1; k <= 22; k++) begin
        logic [2:0] exp;
        tick();
        exp = (k == 8) ? vecs[v].at8 : (k == 11) ? vecs[v].at11 :
              (k == 14) ? vecs[v].at14 : 3'b000;
        check({"vec_", vecs[v].name}, pls_vec(), exp);
        if (k == 10) set_raw(3'b000);
      end
      repeat (10) tick();
    end

    // Bouncing nickel then stable: exactly one pulse
    g_rej = 0; g_pls = '{0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      bus.coin_nickel_raw = ((i / 2) % 2) == 0;
      tick(); observe();
    end
    bus.coin_nickel_raw = 1'b1;
    repeat (30) begin tick(); observe(); end
    check("bounce_nickel_count", g_pls[0], 1);
    check("bounce_other_count", g_pls[1] + g_pls[2], 0);
    bus.coin_nickel_raw = 1'b0;
    repeat (12) tick();

    // Hold with six quarters: queue fills at four, two rejects, then four pulses
    do_reset();
    bus.hold = 1'b1;
    g_rej = 0; g_pls = '{0, 0, 0};
    for (int c = 1; c <= 6; c++) begin
      quarter_coin();
      if (c == 3) check("hold_full_after3", bus.fifo_full, 0);
      if (c == 4) check("hold_full_after4", bus.fifo_full, 1);
    end
    check("hold_reject_count", g_rej, 2);
    check("hold_no_pulses", g_pls[0] + g_pls[1] + g_pls[2], 0);
    check("hold_full_end", bus.fifo_full, 1);
    bus.hold = 1'b0;
    g_pls = '{0, 0, 0};
    repeat (30) begin tick(); observe(); end
    check("release_quarter_count", g_pls[2], 4);
    check("release_other_count", g_pls[0] + g_pls[1], 0);
    check("release_full", bus.fifo_full, 0);
`ifdef COIN_TOTAL_EN
    check("release_total", bus.total_cents, 100);
`endif

    // Reset with a full queue discards everything immediately
    do_reset();
    bus.hold = 1'b1;
    g_rej = 0; g_pls = '{0, 0, 0};
    for (int c = 0; c < 4; c++) quarter_coin();
    check("midq_full_before", bus.fifo_full, 1);
    rst_n = 1'b0;
    #1;
    check("midq_full_async", bus.fifo_full, 0);
    check("midq_pulses_async", pls_vec(), 0);
    check("midq_reject_async", bus.coin_reject, 0);
    tick();
    rst_n = 1'b1;
    bus.hold = 1'b0;
    g_pls = '{0, 0, 0};
    repeat (30) begin tick(); observe(); end
    check("midq_no_pulse_after", g_pls[0] + g_pls[1] + g_pls[2], 0);

    // Dime held high across reset release: one pulse 8 cycles after release
    rst_n = 1'b0;
    bus.coin_dime_raw = 1'b1;
    tick();
    rst_n = 1'b1;
    g_pls = '{0, 0, 0};
    for (int k = 1; k <= 20; k++) begin
      tick(); observe();
      check("rstrel_dime", bus.dime_pls, (k == 8) ? 1 : 0);
    end
    check("rstrel_dime_count", g_pls[1], 1);
    bus.coin_dime_raw = 1'b0;
    repeat (12) tick();

    // Random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       bus.coin_nickel_raw  = ~bus.coin_nickel_raw;
          1:       bus.coin_dime_raw    = ~bus.coin_dime_raw;
          default: bus.coin_quarter_raw = ~bus.coin_quarter_raw;
        endcase
      end
      if ($urandom_range(0, 39) == 0) bus.hold = ~bus.hold;
      if (i == 2000) rst_n = 1'b0;
      if (i == 2001) rst_n = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
